ext_bus_arbiter: RTL and testbench
==================================

// Module: ext_bus_arbiter
// PURPOSE
//  Shares one external memory bus (valid/ready, 32-bit address/data, 4-bit write strobe, instruction flag) between two masters.
//  Typical use: core (m0) and a DMA or debug master (m1) in front of the single external memory port.
//  Round-robin or fixed-priority grant; one transaction in flight; ready is routed only to the granted master.
// PARAMETERS
//  ROUND_ROBIN  1   1 = alternate priority after each completed transfer; 0 = m0 always wins ties
//  TIMEOUT      256 cycles in BUSY before forced completion (used only with ARB_TIMEOUT_EN); min 2
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  reset            in   1   asynchronous, active-low reset
//  m0_valid         in   1   m0 request; held with all m0_* request fields stable until m0_ready
//  m0_instruction   in   1   m0 access is an instruction fetch
//  m0_address       in   32  m0 byte address
//  m0_write_data    in   32  m0 store data
//  m0_write_strobe  in   4   m0 byte enables; 0 = read
//  m0_ready         out  1   single-cycle completion pulse to m0
//  m0_read_data     out  32  load data to m0; valid when m0_ready=1
//  m1_*             -    -   identical set for master 1 (m1_valid ... m1_read_data)
//  ext_valid        out  1   request to external bus
//  ext_instruction  out  1   forwarded from granted master
//  ext_address      out  32  forwarded from granted master
//  ext_write_data   out  32  forwarded from granted master
//  ext_write_strobe out  4   forwarded from granted master
//  ext_ready        in   1   external completion pulse
//  ext_read_data    in   32  external load data, valid with ext_ready
//  arb_error        out  1   sticky timeout flag (0 when ARB_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, owner=0, last=1 (so m0 is first under round-robin), ext_valid=0,
//   ext_* request fields=0, m0_ready=m1_ready=0, arb_error=0, timer=0.
//  States: IDLE, BUSY.
//  IDLE: ext_valid=0. If exactly one mX_valid: owner<=X, go BUSY.
//   If both valid: ROUND_ROBIN=1 -> owner<=~last; ROUND_ROBIN=0 -> owner<=0.
//  BUSY: ext_valid=1; ext_* request fields are a combinational mux from the owner's inputs.
//   On ext_ready=1: owner's mX_ready=1 in the same cycle (combinational); last<=owner; go IDLE.
//  Read data: mX_read_data = ext_read_data when owner=X, else 0.
//   The non-owner never sees ready.
//  Latency: request seen in IDLE cycle N -> ext_valid high from cycle N+1.
//   Minimum 2 cycles per transfer; ext_valid is low for 1 IDLE cycle between back-to-back transfers.
//  A valid that rises in the same cycle the other master completes is arbitrated in the following IDLE cycle.
//  ext_ready while in IDLE: ignored, no ready is generated.
//  Owner deasserting valid in BUSY is a protocol violation: the arbiter stays in BUSY with ext_valid=1 until ext_ready.
//  Reset asserted mid-transfer: immediate return to IDLE with outputs at reset values. Any pending ext response is dropped.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - timer counts BUSY cycles and clears on entry to BUSY.
//   - If timer reaches TIMEOUT-1 without ext_ready: owner's ready=1 with read_data=32'h0; arb_error<=1; go IDLE.
//   - arb_error clears only on reset.
//   - ext_ready arriving in the same cycle as the timeout takes precedence: normal completion, no error.
//  ARB_TIMEOUT_EN undefined: no timer logic; BUSY waits indefinitely; arb_error tied 0.
// TESTING
//  1 Reset: hold reset=0 while mX_valid=1 -> ext_valid=0, m0_ready=m1_ready=0, arb_error=0.
//  2 Single read: m0 read addr 32'h100, memory returns 32'hDEADBEEF after 3 cycles
//    -> ext_address=32'h100 from cycle+1; m0_ready pulses once with m0_read_data=32'hDEADBEEF; m1_ready stays 0.
//  3 Contention, ROUND_ROBIN=1: both masters hold valid for 4 transfers -> grant order m0,m1,m0,m1,
//    with one IDLE cycle (ext_valid=0) between transfers.
//  4 ROUND_ROBIN=0: both masters continuously valid -> m0 granted every time; m1 granted only once m0 drops valid.
//  5 Write forwarding: m1 write addr 32'h2000, data 32'h12345678, strobe 4'b0011
//    -> ext_* carry exactly these values while BUSY; m1_ready on ext_ready.
//  6 ARB_TIMEOUT_EN, TIMEOUT=8, ext_ready never asserted
//    -> owner ready at the 8th BUSY cycle, read_data=0, arb_error=1 held.
//    Repeat with ext_ready in that same cycle -> no error.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Two-master arbiter for a single external valid/ready memory bus; one transaction in flight.
// Define ARB_TIMEOUT_EN to add a BUSY-cycle watchdog with a sticky arb_error flag.
module ext_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 256
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instruction,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  output logic        m0_ready,
  output logic [31:0] m0_read_data,

  input  logic        m1_valid,
  input  logic        m1_instruction,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  output logic        m1_ready,
  output logic [31:0] m1_read_data,

  output logic        ext_valid,
  output logic        ext_instruction,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data,

  output logic        arb_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   tmo;
  logic [31:0] rdata;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ext_bus_arbiter: TIMEOUT must be at least 2");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;
  logic          err_q,   err_d;

  // ext_ready in the expiry cycle wins, so it is a normal completion
  assign tmo     = (state_q == BUSY) && (timer_q == TW'(TIMEOUT - 1)) && !ext_ready;
  assign timer_d = (state_q == BUSY) ? timer_q + TW'(1) : '0;
  assign err_d   = err_q | tmo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign arb_error = err_q;
`else
  assign tmo       = 1'b0;
  assign arb_error = 1'b0;
`endif

  assign rdata = tmo ? 32'h0 : ext_read_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_d           = last_q;
    ext_valid        = 1'b0;
    ext_instruction  = 1'b0;
    ext_address      = '0;
    ext_write_data   = '0;
    ext_write_strobe = '0;
    m0_ready         = 1'b0;
    m1_ready         = 1'b0;
    m0_read_data     = '0;
    m1_read_data     = '0;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          if (m0_valid && m1_valid) owner_d = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
          else                      owner_d = m1_valid;
        end
      end
      BUSY: begin
        // Owner dropping valid mid-transfer is ignored; the request stays up until completion
        ext_valid = 1'b1;
        if (owner_q) begin
          ext_instruction  = m1_instruction;
          ext_address      = m1_address;
          ext_write_data   = m1_write_data;
          ext_write_strobe = m1_write_strobe;
          m1_read_data     = rdata;
        end else begin
          ext_instruction  = m0_instruction;
          ext_address      = m0_address;
          ext_write_data   = m0_write_data;
          ext_write_strobe = m0_write_strobe;
          m0_read_data     = rdata;
        end
        if (ext_ready || tmo) begin
          m0_ready = ~owner_q;
          m1_ready = owner_q;
          last_d   = owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Scoreboarded bench for ext_bus_arbiter: a round-robin and a fixed-priority instance share stimulus;
// the instance under test is chosen by sel_fp. Timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_ext_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic        m0_valid, m0_instruction, m1_valid, m1_instruction, ext_ready;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data, ext_read_data;
  logic [3:0]  m0_write_strobe, m1_write_strobe;

  logic        r_m0_ready, r_m1_ready, r_ext_valid, r_ext_instruction, r_arb_error;
  logic [31:0] r_m0_read_data, r_m1_read_data, r_ext_address, r_ext_write_data;
  logic [3:0]  r_ext_write_strobe;
  logic        f_m0_ready, f_m1_ready, f_ext_valid, f_ext_instruction, f_arb_error;
  logic [31:0] f_m0_read_data, f_m1_read_data, f_ext_address, f_ext_write_data;
  logic [3:0]  f_ext_write_strobe;

  bit sel_fp = 1'b0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct { bit m; logic [31:0] data; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ext_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) u_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instruction(m0_instruction), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_ready(r_m0_ready), .m0_read_data(r_m0_read_data),
    .m1_valid(m1_valid), .m1_instruction(m1_instruction), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_ready(r_m1_ready), .m1_read_data(r_m1_read_data),
    .ext_valid(r_ext_valid), .ext_instruction(r_ext_instruction), .ext_address(r_ext_address),
    .ext_write_data(r_ext_write_data), .ext_write_strobe(r_ext_write_strobe),
    .ext_ready(ext_ready), .ext_read_data(ext_read_data), .arb_error(r_arb_error));

  ext_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(8)) u_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instruction(m0_instruction), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_ready(f_m0_ready), .m0_read_data(f_m0_read_data),
    .m1_valid(m1_valid), .m1_instruction(m1_instruction), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_ready(f_m1_ready), .m1_read_data(f_m1_read_data),
    .ext_valid(f_ext_valid), .ext_instruction(f_ext_instruction), .ext_address(f_ext_address),
    .ext_write_data(f_ext_write_data), .ext_write_strobe(f_ext_write_strobe),
    .ext_ready(ext_ready), .ext_read_data(ext_read_data), .arb_error(f_arb_error));

  wire        s_m0_ready      = sel_fp ? f_m0_ready         : r_m0_ready;
  wire        s_m1_ready      = sel_fp ? f_m1_ready         : r_m1_ready;
  wire [31:0] s_m0_read_data  = sel_fp ? f_m0_read_data     : r_m0_read_data;
  wire [31:0] s_m1_read_data  = sel_fp ? f_m1_read_data     : r_m1_read_data;
  wire        s_ext_valid     = sel_fp ? f_ext_valid        : r_ext_valid;
  wire        s_ext_instr     = sel_fp ? f_ext_instruction  : r_ext_instruction;
  wire [31:0] s_ext_address   = sel_fp ? f_ext_address      : r_ext_address;
  wire [31:0] s_ext_wdata     = sel_fp ? f_ext_write_data   : r_ext_write_data;
  wire [3:0]  s_ext_strobe    = sel_fp ? f_ext_write_strobe : r_ext_write_strobe;
  wire        s_arb_error     = sel_fp ? f_arb_error        : r_arb_error;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: every ready pulse from the selected instance must match the next scoreboard entry
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int m = 0; m < 2; m++) begin
        if ((m == 0) ? s_m0_ready : s_m1_ready) begin
          if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_ready: m%0d ready with empty scoreboard at %0t", m, $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_master", 32'(m), 32'(e.m));
            chk("sb_read_data", (m == 0) ? s_m0_read_data : s_m1_read_data, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; ext_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (s_ext_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ext_valid_grant", 32'(s_ext_valid), 32'd1);
  endtask

  // Act as the external memory for one transfer and check what the arbiter forwards
  task automatic serve(input bit exp_m, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input bit instr, input int delay,
                       input logic [31:0] rdata, input bit drop0, input bit drop1);
    wait_busy();
    for (int i = 0; i <= delay; i++) begin
      chk("ext_address", s_ext_address, addr);
      chk("ext_write_data", s_ext_wdata, wd);
      chk("ext_write_strobe", 32'(s_ext_strobe), 32'(strb));
      chk("ext_instruction", 32'(s_ext_instr), 32'(instr));
      chk("early_ready", {30'd0, s_m1_ready, s_m0_ready}, 32'd0);
      if (i < delay) begin @(posedge clk); #1; end
    end
    ext_read_data = rdata;
    ext_ready     = 1'b1;
    sb.push_back('{exp_m, rdata});
    #1;
    chk("owner_ready", 32'(exp_m ? s_m1_ready : s_m0_ready), 32'd1);
    chk("nonowner_ready", 32'(exp_m ? s_m0_ready : s_m1_ready), 32'd0);
    chk("nonowner_read_data", exp_m ? s_m0_read_data : s_m1_read_data, 32'd0);
    @(posedge clk); #1;
    ext_ready     = 1'b0;
    ext_read_data = 32'hBAD0_BAD0;
    if (drop0) m0_valid = 1'b0;
    if (drop1) m1_valid = 1'b0;
    chk("idle_gap", 32'(s_ext_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_instruction = 1'b1; m0_address = 32'h100;  m0_write_data = 32'h0;         m0_write_strobe = 4'h0;
    m1_instruction = 1'b0; m1_address = 32'h2000; m1_write_data = 32'h1234_5678; m1_write_strobe = 4'b0011;
    ext_read_data  = 32'h5555_5555;

    // Reset held with both masters requesting and a stray ext_ready
    reset = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; ext_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rr_ext_valid", 32'(r_ext_valid), 32'd0);
    chk("rst_fp_ext_valid", 32'(f_ext_valid), 32'd0);
    chk("rst_ready", {30'd0, r_m1_ready, r_m0_ready}, 32'd0);
    chk("rst_arb_error", 32'(r_arb_error), 32'd0);
    chk("rst_ext_address", r_ext_address, 32'd0);
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ext_ready_ignored", {30'd0, r_m1_ready, r_m0_ready}, 32'd0);
    ext_ready = 1'b0;

    // Single m0 read with 1-cycle grant latency
    m0_valid = 1'b1;
    chk("latency_idle", 32'(s_ext_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_busy", 32'(s_ext_valid), 32'd1);
    serve(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // m1 write forwarding
    m1_valid = 1'b1;
    serve(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b0, 2, 32'h0000_0F0F, 1'b0, 1'b1);

    // Round-robin contention: m1 was last, so m0 first
    m0_valid = 1'b1; m1_valid = 1'b1;
    serve(1'b0, 32'h100,  32'h0,         4'h0,    1'b1, 1, 32'h1111_1111, 1'b0, 1'b0);
    serve(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b0, 1, 32'h2222_2222, 1'b0, 1'b0);
    serve(1'b0, 32'h100,  32'h0,         4'h0,    1'b1, 1, 32'h3333_3333, 1'b1, 1'b0);
    serve(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b0, 1, 32'h4444_4444, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a transfer
    m0_valid = 1'b1;
    wait_busy();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ext_valid", 32'(s_ext_valid), 32'd0);
    chk("async_rst_ext_address", s_ext_address, 32'd0);
    m0_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Fixed priority: m0 wins every tie, m1 only after m0 drops
    sel_fp = 1'b1;
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    serve(1'b0, 32'h100,  32'h0,         4'h0,    1'b1, 0, 32'hA1A1_0001, 1'b0, 1'b0);
    serve(1'b0, 32'h100,  32'h0,         4'h0,    1'b1, 1, 32'hA1A1_0002, 1'b0, 1'b0);
    serve(1'b0, 32'h100,  32'h0,         4'h0,    1'b1, 0, 32'hA1A1_0003, 1'b1, 1'b0);
    serve(1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 1'b0, 1, 32'hB1B1_0001, 1'b0, 1'b1);
    sel_fp = 1'b0;
    do_reset();

`ifdef ARB_TIMEOUT_EN
    // Timeout: ext_ready never comes, owner released in the 8th BUSY cycle with zero data
    m0_address = 32'h300; m0_valid = 1'b1;
    wait_busy();
    for (int c = 1; c < 8; c++) begin
      chk("tmo_no_early_ready", 32'(s_m0_ready), 32'd0);
      chk("tmo_no_early_error", 32'(s_arb_error), 32'd0);
      @(posedge clk); #1;
    end
    ext_read_data = 32'h7777_7777;
    sb.push_back('{1'b0, 32'h0});
    #1;
    chk("tmo_ready", 32'(s_m0_ready), 32'd1);
    chk("tmo_read_data", s_m0_read_data, 32'd0);
    @(posedge clk); #1;
    m0_valid = 1'b0;
    chk("tmo_error_set", 32'(s_arb_error), 32'd1);
    chk("tmo_back_idle", 32'(s_ext_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_error_sticky", 32'(s_arb_error), 32'd1);
    do_reset();
    chk("tmo_error_cleared", 32'(s_arb_error), 32'd0);

    // ext_ready on the expiry cycle is a normal completion
    m0_valid = 1'b1;
    wait_busy();
    repeat (7) @(posedge clk);
    #1;
    ext_read_data = 32'hCAFE_0008;
    ext_ready     = 1'b1;
    sb.push_back('{1'b0, 32'hCAFE_0008});
    #1;
    chk("tmo_race_ready", 32'(s_m0_ready), 32'd1);
    @(posedge clk); #1;
    ext_ready = 1'b0; m0_valid = 1'b0;
    chk("tmo_race_no_error", 32'(s_arb_error), 32'd0);
`else
    chk("arb_error_tied_low", 32'(s_arb_error), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
